game_flow_ctrl: RTL

Parametrised game-flow controller for the FPGA game top level. It owns the lives counter, the level counter and a respawn/level-transition timer internally, rather than taking lives from outside. It sequences IDLE, RUN, RESPAWN, LEVEL_UP, WIN and GAME_OVER, with an optional PAUSE state. It sits between the input debouncers and the collision detector on one side, and the renderer/score logic on the other.

---
 rtl/game_flow_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: owns lives, level and the respawn/level-up hold timer.
// Optional PAUSE state is compiled in when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
  parameter int START_LIVES = 3,
  parameter int LIVES_W     = 4,
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_W     = 2,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_Start,
  input  logic               i_Collision,
  input  logic               i_Level_Done,
  input  logic               i_Pause,
  output logic [2:0]         o_Game_State,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic               o_Level_Up,
  output logic               o_Hold_Active
);

  localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_RESPAWN   = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_WIN       = 3'd4,
    S_GAME_OVER = 3'd5,
    S_PAUSE     = 3'd6
  } state_t;

  state_t               state_q, state_n;
  logic [LIVES_W-1:0]   lives_q, lives_n;
  logic [LEVEL_W-1:0]   level_q, level_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic                 lu_q, lu_n;
  logic                 hold_q;
  logic                 start_d;
  logic                 start_edge;

  assign start_edge = i_Start & ~start_d;

`ifdef GAME_PAUSE_EN
  logic pause_d;
  logic pause_edge;
  assign pause_edge = i_Pause & ~pause_d;

  // Edge register resets high so a button held through reset needs a fresh press.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) pause_d <= 1'b1;
    else            pause_d <= i_Pause;
  end
`else
  logic unused_pause;
  assign unused_pause = i_Pause;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE;
      lives_q <= '0;
      level_q <= '0;
      timer_q <= '0;
      lu_q    <= 1'b0;
      hold_q  <= 1'b0;
      start_d <= 1'b1;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      level_q <= level_n;
      timer_q <= timer_n;
      lu_q    <= lu_n;
      hold_q  <= (state_n == S_RESPAWN) || (state_n == S_LEVEL_UP);
      start_d <= i_Start;
    end
  end

  always_comb begin
    state_n = state_q;
    lives_n = lives_q;
    level_n = level_q;
    timer_n = timer_q;
    lu_n    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          lives_n = LIVES_INIT;
          level_n = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // Collision outranks level completion, which outranks pause.
        if (i_Collision) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_n = lives_q - LIVES_W'(1);
            timer_n = HOLD_LOAD;
            state_n = S_RESPAWN;
          end else begin
            lives_n = '0;
            state_n = S_GAME_OVER;
          end
        end else if (i_Level_Done) begin
          lu_n = 1'b1;
          if (level_q == LAST_LEVEL) begin
            state_n = S_WIN;
          end else begin
            level_n = level_q + LEVEL_W'(1);
            timer_n = HOLD_LOAD;
            state_n = S_LEVEL_UP;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (pause_edge) begin
          state_n = S_PAUSE;
        end
`endif
      end
      S_RESPAWN, S_LEVEL_UP: begin
        if (timer_q == '0) state_n = S_RUN;
        else               timer_n = timer_q - TIMER_W'(1);
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (pause_edge) state_n = S_RUN;
      end
`endif
      S_WIN, S_GAME_OVER: begin
        if (start_edge) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign o_Game_State  = state_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Level_Up    = lu_q;
  assign o_Hold_Active = hold_q;

endmodule
